add_sub_serial: RTL



---
 rtl/add_sub_serial.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/add_sub_serial.sv
// Serial adder-subtractor: CHUNK bits per clock with a registered ripple carry.
// Optional SATURATE_EN clamps an overflowing result to the extreme value that has the sign of a.
module add_sub_serial #(
  parameter int WIDTH = 8,
  parameter int CHUNK = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             ovf,
  output logic             zero,
  output logic [1:0]       dbg_state
);

  localparam int N  = WIDTH / CHUNK;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_bx;
  logic [WIDTH-1:0] r_work;
  logic [WIDTH-1:0] r_result;
  logic [CW-1:0]    r_count;
  logic             r_carry;
  logic             r_cout;
  logic             r_ovf;
  logic             r_zero;
  logic [CHUNK-1:0] w_a_sl;
  logic [CHUNK-1:0] w_bx_sl;
  logic [CHUNK-1:0] w_sum;
  logic             w_csl;
  logic             w_cmsb;
  logic             w_ovf;
  logic             w_last;
  logic [WIDTH-1:0] w_final;
  logic [WIDTH-1:0] w_res_out;

  assign w_a_sl  = r_a[r_count*CHUNK +: CHUNK];
  assign w_bx_sl = r_bx[r_count*CHUNK +: CHUNK];
  assign {w_csl, w_sum} = {1'b0, w_a_sl} + {1'b0, w_bx_sl} + {{CHUNK{1'b0}}, r_carry};
  // Carry into the top bit of the slice, recovered from that bit's sum and operands.
  assign w_cmsb = w_sum[CHUNK-1] ^ w_a_sl[CHUNK-1] ^ w_bx_sl[CHUNK-1];
  assign w_ovf  = w_cmsb ^ w_csl;
  assign w_last = (r_count == CW'(N - 1));

  always_comb begin
    w_final = r_work;
    w_final[r_count*CHUNK +: CHUNK] = w_sum;
  end

`ifdef SATURATE_EN
  assign w_res_out = w_ovf ? (r_a[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                           : {1'b0, {(WIDTH-1){1'b1}}})
                           : w_final;
`else
  assign w_res_out = w_final;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // Handshake: start is taken only when busy=0; busy stays high through RUN and DONE,
  // and done is a single-cycle pulse in which result and flags are already valid.
  always_comb begin
    w_next = r_state;
    busy   = 1'b0;
    done   = 1'b0;
    case (r_state)
      S_IDLE: if (start) w_next = S_RUN;
      S_RUN: begin
        busy = 1'b1;
        if (w_last) w_next = S_DONE;
      end
      S_DONE: begin
        busy   = 1'b1;
        done   = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a      <= '0;
      r_bx     <= '0;
      r_work   <= '0;
      r_result <= '0;
      r_count  <= '0;
      r_carry  <= 1'b0;
      r_cout   <= 1'b0;
      r_ovf    <= 1'b0;
      r_zero   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_a     <= a;
            r_bx    <= b ^ {WIDTH{mode}};
            r_carry <= mode;
            r_count <= '0;
          end
        end
        S_RUN: begin
          r_work[r_count*CHUNK +: CHUNK] <= w_sum;
          r_carry <= w_csl;
          // Visible outputs change only here, so they never show a partial sum.
          if (w_last) begin
            r_result <= w_res_out;
            r_cout   <= w_csl;
            r_ovf    <= w_ovf;
            r_zero   <= (w_res_out == '0);
          end else begin
            r_count <= r_count + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign result    = r_result;
  assign cout      = r_cout;
  assign ovf       = r_ovf;
  assign zero      = r_zero;
  assign dbg_state = r_state;

endmodule
